sdram_port_arbiter: RTL and testbench

- Two-master arbiter that shares the single SDRAM controller Avalon-MM slave port in the lab SoC.
- Master 0 is the video line fetcher; master 1 is the game/keycode logic.
- Grants the port round-robin with a bounded hold count.
- Tracks outstanding pipelined reads in a tag FIFO so that each readdatavalid is routed back to the master that issued the read.

---
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller slave port.
// A tag FIFO remembers which master issued each pipelined read so returns are routed back.
module sdram_port_arbiter #(
    parameter  int ADDR_W      = 25,
    parameter  int DATA_W      = 16,
    parameter  int MAX_PENDING = 8,
    parameter  int HOLD_MAX    = 16,
    localparam int BE_W        = DATA_W / 8,
    localparam int CNT_W       = $clog2(MAX_PENDING) + 1,
    localparam int PTR_W       = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1,
    localparam int HOLD_W      = $clog2(HOLD_MAX + 1)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [CNT_W-1:0]  pending,
    output logic              err_orphan
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_eff;
    logic              tag_q [MAX_PENDING];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_orphan_q;

    logic req0, req1, gnt_id, sel_read, sel_write, eff_read, stall;
    logic cur_req, oth_req, fifo_full, fifo_empty, accept, idle_bus, push, pop, head_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign fifo_full  = (count_q == CNT_W'(MAX_PENDING));
    assign fifo_empty = (count_q == '0);
    assign head_tag   = tag_q[rd_ptr_q];

    // The slave-side mux follows the registered grant only, never the requests.
    always_comb begin
        gnt_id       = (state_q == GRANT1);
        sel_read     = gnt_id ? m1_read       : m0_read;
        sel_write    = gnt_id ? m1_write      : m0_write;
        s_address    = gnt_id ? m1_address    : m0_address;
        s_writedata  = gnt_id ? m1_writedata  : m0_writedata;
        s_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
        // A read presented together with a write is ignored; the write wins.
        eff_read       = sel_read & ~sel_write;
        s_write        = (state_q != IDLE) & sel_write;
        s_read         = (state_q != IDLE) & eff_read & ~fifo_full;
        stall          = s_waitrequest | (eff_read & fifo_full);
        m0_waitrequest = (state_q != GRANT0) | stall;
        m1_waitrequest = (state_q != GRANT1) | stall;
    end

    assign accept   = (s_read | s_write) & ~s_waitrequest;
    assign idle_bus = ~(s_read | s_write) | ~s_waitrequest;
    assign push     = accept & s_read;
    assign pop      = s_readdatavalid & ~fifo_empty;

    // hold_eff includes this cycle's accept, so the yield lands right after the last allowed transfer.
    assign hold_eff = (accept && hold_cnt_q != HOLD_W'(HOLD_MAX)) ? hold_cnt_q + HOLD_W'(1) : hold_cnt_q;

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_eff;
        cur_req      = gnt_id ? req1 : req0;
        oth_req      = gnt_id ? req0 : req1;
        case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_grant_q ? GRANT0 : GRANT1;
                else if (req0)     state_d = GRANT0;
                else if (req1)     state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (idle_bus && (!cur_req || (hold_eff == HOLD_W'(HOLD_MAX) && oth_req))) begin
                    state_d      = !oth_req ? IDLE : (gnt_id ? GRANT0 : GRANT1);
                    last_grant_d = gnt_id;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) hold_cnt_d = '0;
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (s_readdatavalid && fifo_empty) err_orphan_q <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk_clk) begin
        if (push) tag_q[wr_ptr_q] <= gnt_id;
    end

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_tag;
    assign m1_readdatavalid = pop &  head_tag;
    assign pending          = count_q;
    assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, hold limit, tag FIFO full/routing, orphan returns.
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25, DATA_W = 16, MAX_PENDING = 8, HOLD_MAX = 4, BE_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_PENDING) + 1;

    logic              clk, rst_n;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [DATA_W-1:0] s_writedata, s_readdata;
    logic [CNT_W-1:0]  pending;
    logic              err_orphan;

    int n_pass  = 0;
    int n_total = 0;
    int n0, n1;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .pending(pending), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic count_accepts(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        if (s_read && !s_waitrequest && s_address == a0) n0++;
        if (s_read && !s_waitrequest && s_address == a1) n1++;
    endtask

    initial begin
        // Reset state, with requests and a stray return driven to prove reset dominates
        rst_n = 0;
        clear_inputs();
        m0_read = 1; m1_read = 1; s_readdatavalid = 1;
        #12;
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_m0_wait", m0_waitrequest, 1);
        check("rst_m1_wait", m1_waitrequest, 1);
        check("rst_m0_rdv", m0_readdatavalid, 0);
        check("rst_m1_rdv", m1_readdatavalid, 0);
        check("rst_pending", pending, 0);
        check("rst_err", err_orphan, 0);
        clear_inputs();
        tick();
        rst_n = 1;

        // Single master read with a delayed return
        m1_address = 25'h000100; m1_read = 1; #1;
        check("t1_idle_sread", s_read, 0);
        check("t1_idle_m1_wait", m1_waitrequest, 1);
        tick(); #1;
        check("t1_sread", s_read, 1);
        check("t1_saddr", s_address, 32'h100);
        check("t1_m1_wait", m1_waitrequest, 0);
        tick(); m1_read = 0; #1;
        check("t1_pending1", pending, 1);
        check("t1_sread_off", s_read, 0);
        tick();
        tick(); s_readdatavalid = 1; s_readdata = 16'hBEEF; #1;
        check("t1_m1_rdv", m1_readdatavalid, 1);
        check("t1_m1_data", m1_readdata, 32'hBEEF);
        check("t1_m0_rdv", m0_readdatavalid, 0);
        tick(); s_readdatavalid = 0; #1;
        check("t1_pending0", pending, 0);

        // Simultaneous first request after reset: m0 first, then direct switch to m1
        do_reset();
        m0_address = 25'h10; m1_address = 25'h20; m0_read = 1; m1_read = 1; #1;
        check("t2_idle_m0_wait", m0_waitrequest, 1);
        tick(); #1;
        check("t2_g0_addr", s_address, 32'h10);
        check("t2_g0_m0_wait", m0_waitrequest, 0);
        check("t2_g0_m1_wait", m1_waitrequest, 1);
        tick(); #1;
        check("t2_g0_second", s_read, 1);
        tick(); m0_read = 0; #1;
        check("t2_pending2", pending, 2);
        check("t2_drop_sread", s_read, 0);
        tick(); #1;
        check("t2_g1_addr", s_address, 32'h20);
        check("t2_g1_sread", s_read, 1);
        check("t2_g1_m1_wait", m1_waitrequest, 0);
        check("t2_g1_m0_wait", m0_waitrequest, 1);
        tick(); m1_read = 0; #1;
        check("t2_pending3", pending, 3);

        // Reset with three reads in flight, then a late return
        rst_n = 0; m0_read = 1; #1;
        check("t6_rst_pending", pending, 0);
        check("t6_rst_sread", s_read, 0);
        tick(); tick();
        rst_n = 1; m0_read = 0; s_readdatavalid = 1; s_readdata = 16'h5555; #1;
        check("t6_late_m0_rdv", m0_readdatavalid, 0);
        check("t6_late_m1_rdv", m1_readdatavalid, 0);
        tick(); s_readdatavalid = 0; #1;
        check("t6_err_orphan", err_orphan, 1);
        check("t6_idle_m0_wait", m0_waitrequest, 1);
        check("t6_idle_m1_wait", m1_waitrequest, 1);

        // Hold limit: m0 streams while m1 waits
        do_reset();
        check("t3_err_cleared", err_orphan, 0);
        m0_address = 25'h40; m1_address = 25'h50; m0_read = 1; m1_read = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            count_accepts(25'h40, 25'h50);
        end
        check("t3_m0_accepts", n0, 4);
        check("t3_m1_accepts", n1, 2);
        check("t3_m0_wait", m0_waitrequest, 1);
        check("t3_pending", pending, 5);
        m0_read = 0; m1_read = 0;

        // FIFO full: 10 reads attempted with no returns
        do_reset();
        m0_address = 25'h77; m0_read = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            count_accepts(25'h77, 25'h1FFFFFF);
        end
        check("t4_accepts", n0, 8);
        check("t4_full_sread", s_read, 0);
        check("t4_full_wait", m0_waitrequest, 1);
        check("t4_pending8", pending, 8);
        s_readdatavalid = 1; s_readdata = 16'h0A0A; #1;
        check("t4_ret_rdv", m0_readdatavalid, 1);
        check("t4_ret_sread", s_read, 0);
        tick(); s_readdatavalid = 0; #1;
        check("t4_slot_pending", pending, 7);
        check("t4_slot_sread", s_read, 1);
        check("t4_slot_wait", m0_waitrequest, 0);
        tick(); #1;
        check("t4_refull_sread", s_read, 0);
        check("t4_refull_pending", pending, 8);
        m0_read = 0;

        // Interleaved returns routed 0,0,1,1 with a push/pop overlap
        do_reset();
        m0_address = 25'h1; m1_address = 25'h2; m0_read = 1; m1_read = 1;
        tick();
        tick();
        tick(); m0_read = 0; #1;
        check("t5_gap_sread", s_read, 0);
        tick(); #1;
        check("t5_g1_addr", s_address, 32'h2);
        check("t5_pending2", pending, 2);
        tick(); s_readdatavalid = 1; s_readdata = 16'h1111; #1;
        check("t5_pre_pending", pending, 3);
        check("t5_r0_m0", m0_readdatavalid, 1);
        check("t5_r0_m1", m1_readdatavalid, 0);
        check("t5_r0_push", s_read, 1);
        tick(); m1_read = 0; s_readdata = 16'h2222; #1;
        check("t5_pushpop_pending", pending, 3);
        check("t5_r1_m0", m0_readdatavalid, 1);
        check("t5_r1_m1", m1_readdatavalid, 0);
        check("t5_r1_data", m0_readdata, 32'h2222);
        tick(); s_readdata = 16'h3333; #1;
        check("t5_r2_m1", m1_readdatavalid, 1);
        check("t5_r2_m0", m0_readdatavalid, 0);
        check("t5_r2_pending", pending, 2);
        tick(); s_readdata = 16'h4444; #1;
        check("t5_r3_m1", m1_readdatavalid, 1);
        check("t5_r3_pending", pending, 1);
        tick(); s_readdatavalid = 0; #1;
        check("t5_pending0", pending, 0);
        check("t5_no_orphan", err_orphan, 0);

        // Write with stall; simultaneous read is ignored
        m1_address = 25'h3; m1_write = 1; m1_read = 1; m1_writedata = 16'hCAFE;
        m1_byteenable = 2'b10; s_waitrequest = 1;
        tick(); m0_address = 25'h4; m0_read = 1; #1;
        check("t7_swrite", s_write, 1);
        check("t7_sread_masked", s_read, 0);
        check("t7_wdata", s_writedata, 32'hCAFE);
        check("t7_be", s_byteenable, 2);
        check("t7_m1_stall", m1_waitrequest, 1);
        tick(); #1;
        check("t7_held_addr", s_address, 32'h3);
        s_waitrequest = 0; #1;
        check("t7_m1_go", m1_waitrequest, 0);
        tick(); m1_write = 0; m1_read = 0; #1;
        check("t7_no_tag", pending, 0);
        check("t7_swrite_off", s_write, 0);
        tick(); #1;
        check("t7_g0_addr", s_address, 32'h4);
        check("t7_g0_sread", s_read, 1);
        m0_read = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
